guardado_datos: RTL and testbench

Operand capture block for the BCD calculator datapath. Latches two successive 4-digit BCD numbers from the keypad/entry logic on user "save" requests. It presents the most recently saved number for display. Once both operands are held, it flags that an addition may proceed and drives both operands to the downstream adder.

---
 rtl/calc_pkg.sv | 21 ++
 rtl/guardado_datos_rise_detect.sv | 26 ++
 rtl/guardado_datos.sv | 117 +++++++++++
 tb/tb_guardado_datos.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the BCD calculator datapath.
//   N_DIGITS    digits per operand
//   DIGIT_W     bits per BCD digit
//   bcd_digit_t single BCD digit
//   bcd_num_t   full operand, index N_DIGITS-1 is the most significant digit
//   sv_state_t  operand capture state (EMPTY, ONE, TWO)
package calc_pkg;

    localparam int N_DIGITS = 4;
    localparam int DIGIT_W  = 4;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [N_DIGITS-1:0] bcd_num_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } sv_state_t;

endpackage

// File: rtl/guardado_datos_rise_detect.sv
// rise_detect: 1-bit synchronous rising-edge detector.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset, clears the delayed copy
//   din   level input
//   rise  high for the cycle where din is 1 and was 0 at the previous edge
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/guardado_datos.sv
// guardado_datos: captures two successive BCD operands on save requests.
// Ports:
//   clk        system clock
//   rst        synchronous active-high global reset
//   guardar    save request level, one save per rising edge
//   rst_sv     synchronous active-high clear of the saved operands
//   numero     number being entered (sampled only on a save)
//   numero_sv  most recently saved number
//   suma       high while both operands are held
//   op_a       first saved operand
//   op_b       second saved operand
// Build option: GUARDADO_BCD_CHECK_EN rejects saves where any digit exceeds 9.
//
// state | meaning
// EMPTY | no operand held
// ONE   | op_a held, waiting for op_b
// TWO   | both operands held, further saves ignored
module guardado_datos
    import calc_pkg::*;
#(
    parameter int N_DIGITS = calc_pkg::N_DIGITS,
    parameter int DIGIT_W  = calc_pkg::DIGIT_W
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               guardar,
    input  logic                               rst_sv,
    input  logic [N_DIGITS-1:0][DIGIT_W-1:0]   numero,
    output logic [N_DIGITS-1:0][DIGIT_W-1:0]   numero_sv,
    output logic                               suma,
    output logic [N_DIGITS-1:0][DIGIT_W-1:0]   op_a,
    output logic [N_DIGITS-1:0][DIGIT_W-1:0]   op_b
);

    sv_state_t                         state_q, state_d;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]  num_sv_q, num_sv_d;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]  op_a_q, op_a_d;
    logic [N_DIGITS-1:0][DIGIT_W-1:0]  op_b_q, op_b_d;
    logic                              suma_q, suma_d;
    logic                              save;
    logic                              digits_ok;

    // The edge register keeps following guardar through rst_sv so that a
    // held button does not produce a fresh save once the clear is released.
    rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .din  (guardar),
        .rise (save)
    );

    always_comb begin
        digits_ok = 1'b1;
`ifdef GUARDADO_BCD_CHECK_EN
        for (int i = 0; i < N_DIGITS; i++) begin
            if (numero[i] > DIGIT_W'(9)) begin
                digits_ok = 1'b0;
            end
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        num_sv_d = num_sv_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        if (rst_sv) begin
            state_d  = EMPTY;
            num_sv_d = '0;
            op_a_d   = '0;
            op_b_d   = '0;
        end else if (save && digits_ok) begin
            case (state_q)
                EMPTY: begin
                    op_a_d   = numero;
                    num_sv_d = numero;
                    state_d  = ONE;
                end
                ONE: begin
                    op_b_d   = numero;
                    num_sv_d = numero;
                    state_d  = TWO;
                end
                TWO: begin
                    state_d = TWO;
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        suma_d = (state_d == TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            num_sv_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            suma_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_sv_q <= num_sv_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            suma_q   <= suma_d;
        end
    end

    assign numero_sv = num_sv_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign suma      = suma_q;

endmodule

// File: tb/tb_guardado_datos.sv
module tb_guardado_datos;

    typedef struct {
        logic [15:0] nsv;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        guardar;
    logic        rst_sv;
    logic [3:0][3:0] numero;
    logic [3:0][3:0] numero_sv;
    logic        suma;
    logic [3:0][3:0] op_a;
    logic [3:0][3:0] op_b;

    int checks = 0;
    int errors = 0;
    bit done   = 0;

    exp_t exp_q[$];

    // Reference model: list of accepted operands plus previous guardar level.
    logic [15:0] saved[$];
    logic        prev_g = 1'b0;

    guardado_datos dut (
        .clk       (clk),
        .rst       (rst),
        .guardar   (guardar),
        .rst_sv    (rst_sv),
        .numero    (numero),
        .numero_sv (numero_sv),
        .suma      (suma),
        .op_a      (op_a),
        .op_b      (op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit digits_valid(input logic [15:0] n);
`ifdef GUARDADO_BCD_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            if (((n >> (4 * i)) & 16'hF) > 16'd9) return 1'b0;
        end
`endif
        return 1'b1;
    endfunction

    // Apply inputs for the next rising edge, advance the model and queue
    // the outputs expected just after that edge.
    task automatic step(input logic r, input logic rs, input logic g, input logic [15:0] n);
        exp_t e;
        rst     = r;
        rst_sv  = rs;
        guardar = g;
        numero  = n;
        if (r) begin
            saved.delete();
            prev_g = 1'b0;
        end else begin
            if (rs) begin
                saved.delete();
            end else if (g && !prev_g && saved.size() < 2 && digits_valid(n)) begin
                saved.push_back(n);
            end
            prev_g = g;
        end
        e.a   = (saved.size() >= 1) ? saved[0] : 16'h0000;
        e.b   = (saved.size() >= 2) ? saved[1] : 16'h0000;
        e.nsv = (saved.size() >= 1) ? saved[saved.size()-1] : 16'h0000;
        e.s   = (saved.size() == 2);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are registered, so compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk16("numero_sv", numero_sv, e.nsv);
                chk16("op_a", op_a, e.a);
                chk16("op_b", op_b, e.b);
                chk16("suma", {15'd0, suma}, {15'd0, e.s});
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic g;
        logic [15:0] n;
        // Reset held two cycles.
        step(1, 0, 0, 16'h0000);
        step(1, 0, 0, 16'h0000);
        step(0, 0, 0, 16'h0000);
        // First and second operands.
        step(0, 0, 0, 16'h2165);
        step(0, 0, 1, 16'h2165);
        step(0, 0, 0, 16'h2165);
        step(0, 0, 0, 16'h9341);
        step(0, 0, 1, 16'h9341);
        step(0, 0, 0, 16'h5555);
        // Third save in TWO is ignored.
        step(0, 0, 1, 16'h7777);
        step(0, 0, 0, 16'h7777);
        // Clear, then reload op_a.
        step(0, 1, 0, 16'h0000);
        step(0, 0, 1, 16'h4321);
        step(0, 0, 0, 16'h4321);
        step(0, 1, 0, 16'h0000);
        // Held guardar gives a single save.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h1234);
        step(0, 0, 0, 16'h1234);
        // Save coinciding with rst_sv is discarded; held level after clear no save.
        step(0, 1, 1, 16'h8888);
        step(0, 0, 1, 16'h8888);
        step(0, 0, 0, 16'h8888);
        // Non-BCD digit (rejected only with the check enabled), then valid.
        step(0, 0, 1, 16'h12A4);
        step(0, 0, 0, 16'h12A4);
        step(0, 0, 1, 16'h1294);
        step(0, 0, 0, 16'h1294);
        step(0, 1, 0, 16'h0000);
        step(0, 0, 1, 16'h12A4);
        step(0, 0, 0, 16'h12A4);
        step(0, 0, 1, 16'h1294);
        step(0, 0, 0, 16'h1294);
        // Randomized traffic.
        g = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) g = ~g;
            n = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int d = 0; d < 4; d++) begin
                    n[4*d +: 4] = 4'($urandom_range(0, 9));
                end
            end
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 14) == 0), g, n);
        end
        step(0, 0, 0, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
